lockout_controller: RTL and testbench

- Clocked supervisor sitting directly downstream of the password comparator; consumes one verdict per completed entry (pass_ok qualified by attempt_valid).
- Keeps the registered wrong-attempt count and drives the door, lock and alarm outputs:
  - timed door open on a correct entry;
  - timed lockout after each wrong entry;
  - latched alarm at MAX_FAILS;
  - fire-alarm override.

---
 rtl/security_pkg.sv | 42 ++++
 rtl/lockout_controller_down_timer.sv | 49 ++++
 rtl/lockout_controller.sv | 212 +++++++++++++++++++++
 tb/tb_lockout_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/security_pkg.sv
// ---------------------------------------------------------------------------
// security_pkg
// Shared definitions for the keypad security chain: the lockout FSM state
// encoding, the fail-counter width and the default policy constants. The
// comparator and display stages import the same constants, so every stage
// uses the same values.
// ---------------------------------------------------------------------------
package security_pkg;

    // Width of the wrong-attempt counter.
    localparam int CNT_W = 3;

    // Default policy: wrong entries before the alarm latches, and the lockout
    // and door-open durations in clock cycles.
    localparam int MAX_FAILS_DEF   = 3;
    localparam int LOCK_CYCLES_DEF = 1000;
    localparam int OPEN_CYCLES_DEF = 500;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPEN    = 3'd1,
        ST_LOCKOUT = 3'd2,
        ST_ALARM   = 3'd3,
        ST_FIRE    = 3'd4
    } lock_state_e;

    // The door actuator is released in OPEN and during a fire override.
    function automatic logic state_door_open(input lock_state_e s);
        return (s == ST_OPEN) || (s == ST_FIRE);
    endfunction

    // New entries are refused while locked out or while the alarm is latched.
    function automatic logic state_locked(input lock_state_e s);
        return (s == ST_LOCKOUT) || (s == ST_ALARM);
    endfunction

    // The siren sounds on a latched alarm and during a fire override.
    function automatic logic state_alarm(input lock_state_e s);
        return (s == ST_ALARM) || (s == ST_FIRE);
    endfunction

endpackage

// File: rtl/lockout_controller_down_timer.sv
// ---------------------------------------------------------------------------
// down_timer
// Loadable down-counter that stops at zero. The OPEN and LOCKOUT states share
// one instance.
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset (count cleared)
//   load_i      load load_val_i this cycle (has priority over tick_i)
//   load_val_i  reload value
//   tick_i      decrement by one if not already zero
//   zero_o      current count is zero
// ---------------------------------------------------------------------------
module down_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/lockout_controller.sv
// ---------------------------------------------------------------------------
// lockout_controller
// Supervisor downstream of the password comparator. It takes one verdict per
// completed entry and drives the door, lock and alarm outputs: a timed door
// opening on a correct entry, a timed lockout after each wrong entry, a
// latched alarm after MAX_FAILS wrong entries, and a fire override.
//   clk, rst_n      clock / asynchronous active-low reset
//   attempt_valid   one-cycle pulse, pass_ok valid
//   pass_ok         1 = password correct
//   fire_alarm      level, forces door open + siren
//   alarm_disable   one-cycle admin pulse, clears count, leaves ALARM/LOCKOUT
//   door_open       unlock actuator
//   locked          entries refused (LOCKOUT or ALARM)
//   alarm           siren
//   fail_count      registered wrong-attempt count
//   attempt_ack     entry accepted and evaluated
//   attempt_rej     entry discarded
// All outputs are registered and follow the inputs with one cycle of latency.
// ---------------------------------------------------------------------------
module lockout_controller
    import security_pkg::*;
#(
    parameter int MAX_FAILS   = MAX_FAILS_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
    parameter int OPEN_CYCLES = OPEN_CYCLES_DEF,
    parameter int CNT_W       = security_pkg::CNT_W,
    parameter int TMR_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             attempt_valid,
    input  logic             pass_ok,
    input  logic             fire_alarm,
    input  logic             alarm_disable,
    output logic             door_open,
    output logic             locked,
    output logic             alarm,
    output logic [CNT_W-1:0] fail_count,
    output logic             attempt_ack,
    output logic             attempt_rej
);

    // Reject parameter sets that the timer or the counter cannot represent.
    if ((LOCK_CYCLES < 1) || (OPEN_CYCLES < 1) ||
        (LOCK_CYCLES > (32'sd1 <<< TMR_W)) || (OPEN_CYCLES > (32'sd1 <<< TMR_W))) begin : g_tmr_chk
        $error("lockout_controller: cycle counts must be 1..2**TMR_W");
    end
    if ((MAX_FAILS < 1) || (MAX_FAILS > ((32'sd1 <<< CNT_W) - 32'sd1))) begin : g_cnt_chk
        $error("lockout_controller: MAX_FAILS must be 1..2**CNT_W-1");
    end

    // Timer reloads are "cycles - 1": the state lasts through the cycle in
    // which the timer reads zero, which gives exactly the requested length.
    localparam logic [TMR_W-1:0] OPEN_RELOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_RELOAD = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_FAILS);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic [CNT_W-1:0] next_fail_s;
    logic             door_open_q, door_open_d;
    logic             locked_q, locked_d;
    logic             alarm_q, alarm_d;
    logic             ack_q, ack_d;
    logic             rej_q, rej_d;
    logic             tmr_load_s;
    logic [TMR_W-1:0] tmr_val_s;
    logic             tmr_tick_s;
    logic             tmr_zero_s;

    down_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .tick_i     (tmr_tick_s),
        .zero_o     (tmr_zero_s)
    );

    // Count after one more wrong entry. The counter only advances in IDLE,
    // and IDLE is never reached with the count at MAX_FAILS, so it cannot wrap.
    assign next_fail_s = fail_count_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // State register and wrong-attempt count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fail_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Next state, count, timer control and handshake.
    // Priority: fire_alarm > alarm_disable > attempt_valid.
    always_comb begin
        state_d      = state_q;
        fail_count_d = fail_count_q;
        tmr_load_s   = 1'b0;
        tmr_val_s    = {TMR_W{1'b0}};
        tmr_tick_s   = 1'b0;
        ack_d        = 1'b0;
        rej_d        = 1'b0;
        if (fire_alarm) begin
            state_d      = ST_FIRE;
            fail_count_d = {CNT_W{1'b0}};
            tmr_load_s   = 1'b1;
            rej_d        = attempt_valid;
        end else if (alarm_disable) begin
            // An entry coinciding with the admin pulse is never evaluated.
            fail_count_d = {CNT_W{1'b0}};
            rej_d        = attempt_valid;
            case (state_q)
                ST_OPEN: begin
                    // A door already open runs its normal countdown.
                    if (tmr_zero_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_tick_s = 1'b1;
                    end
                end
                default: begin
                    // IDLE, LOCKOUT, ALARM, and FIRE with the fire input now low.
                    state_d    = ST_IDLE;
                    tmr_load_s = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (attempt_valid) begin
                        ack_d = 1'b1;
                        if (pass_ok) begin
                            fail_count_d = {CNT_W{1'b0}};
                            tmr_load_s   = 1'b1;
                            tmr_val_s    = OPEN_RELOAD;
                            state_d      = ST_OPEN;
                        end else if (next_fail_s == MAX_CNT) begin
                            fail_count_d = next_fail_s;
                            state_d      = ST_ALARM;
                        end else begin
                            fail_count_d = next_fail_s;
                            tmr_load_s   = 1'b1;
                            tmr_val_s    = LOCK_RELOAD;
                            state_d      = ST_LOCKOUT;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_OPEN, ST_LOCKOUT: begin
                    rej_d = attempt_valid;
                    if (tmr_zero_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_tick_s = 1'b1;
                    end
                end
                ST_ALARM: begin
                    rej_d   = attempt_valid;
                    state_d = ST_ALARM;
                end
                ST_FIRE: begin
                    // First cycle with the fire input low.
                    rej_d   = attempt_valid;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d      = ST_IDLE;
                    fail_count_d = {CNT_W{1'b0}};
                    tmr_load_s   = 1'b1;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the state register.
    always_comb begin
        door_open_d = state_door_open(state_d);
        locked_d    = state_locked(state_d);
        alarm_d     = state_alarm(state_d);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_open_q <= 1'b0;
            locked_q    <= 1'b0;
            alarm_q     <= 1'b0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
        end else begin
            door_open_q <= door_open_d;
            locked_q    <= locked_d;
            alarm_q     <= alarm_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
        end
    end

    assign door_open   = door_open_q;
    assign locked      = locked_q;
    assign alarm       = alarm_q;
    assign fail_count  = fail_count_q;
    assign attempt_ack = ack_q;
    assign attempt_rej = rej_q;

endmodule

// File: tb/tb_lockout_controller.sv
// ---------------------------------------------------------------------------
// tb_lockout_controller
// Directed stimulus with MAX_FAILS=3, LOCK_CYCLES=4, OPEN_CYCLES=3. The driver
// pushes the expected output vector for a given cycle into a queue; the
// monitor pops entries when their cycle arrives (or on an explicit probe
// between edges) and compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_lockout_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       attempt_valid = 1'b0;
    logic       pass_ok = 1'b0;
    logic       fire_alarm = 1'b0;
    logic       alarm_disable = 1'b0;
    logic       door_open;
    logic       locked;
    logic       alarm;
    logic [2:0] fail_count;
    logic       attempt_ack;
    logic       attempt_rej;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   probe_tgl = 1'b0;

    lockout_controller #(
        .MAX_FAILS   (3),
        .LOCK_CYCLES (4),
        .OPEN_CYCLES (3),
        .CNT_W       (3),
        .TMR_W       (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .attempt_valid (attempt_valid),
        .pass_ok       (pass_ok),
        .fire_alarm    (fire_alarm),
        .alarm_disable (alarm_disable),
        .door_open     (door_open),
        .locked        (locked),
        .alarm         (alarm),
        .fail_count    (fail_count),
        .attempt_ack   (attempt_ack),
        .attempt_rej   (attempt_rej)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk or probe_tgl) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = {door_open, locked, alarm, fail_count, attempt_ack, attempt_rej};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s cyc=%0d door/lock/alarm/cnt/ack/rej got %b_%b_%b_%0d_%b_%b want %b_%b_%b_%0d_%b_%b",
                         e.name, cyc, act[7], act[6], act[5], act[4:2], act[1], act[0],
                         e.vec[7], e.vec[6], e.vec[5], e.vec[4:2], e.vec[1], e.vec[0]);
            end
        end
    end

    // Queue an expectation 'off' cycles from now, keeping the queue sorted.
    task automatic push_exp(input int off, input logic d, input logic l, input logic a,
                            input logic [2:0] c, input logic ak, input logic rj,
                            input string nm);
        exp_t e;
        int   i;
        e.cyc  = cyc + off;
        e.vec  = {d, l, a, c, ak, rj};
        e.name = nm;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > e.cyc) i--;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wrong entry from IDLE that is expected to cause a 4-cycle lockout.
    task automatic wrong_entry(input logic [2:0] c, input string nm);
        attempt_valid = 1'b1;
        pass_ok       = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b0, c, 1'b1, 1'b0, {nm, "_ack"});
        for (int i = 2; i <= 4; i++) push_exp(i, 1'b0, 1'b1, 1'b0, c, 1'b0, 1'b0, {nm, "_lock"});
        push_exp(5, 1'b0, 1'b0, 1'b0, c, 1'b0, 1'b0, {nm, "_end"});
        step(1);
        attempt_valid = 1'b0;
        step(4);
    endtask

    initial begin
        step(1);
        // Reset held low.
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "reset_hold");
        step(1);
        rst_n = 1'b1;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "reset_idle");
        step(1);

        // Single wrong entry; a second entry during lockout is rejected.
        attempt_valid = 1'b1;
        pass_ok       = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, "w1_ack");
        step(1);
        pass_ok = 1'b1;
        push_exp(1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, "w1_rej");
        step(1);
        attempt_valid = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, "w1_lock3");
        push_exp(2, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, "w1_lock4");
        push_exp(3, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, "w1_end");
        step(3);

        // Second wrong entry, then a correct entry with fail_count=2.
        wrong_entry(3'd2, "w2");
        attempt_valid = 1'b1;
        pass_ok       = 1'b1;
        push_exp(1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "open_ack");
        push_exp(2, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "open_2");
        push_exp(3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "open_3");
        push_exp(4, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "open_end");
        step(1);
        attempt_valid = 1'b0;
        step(3);

        // Three wrong entries latch the alarm.
        wrong_entry(3'd1, "a1");
        wrong_entry(3'd2, "a2");
        attempt_valid = 1'b1;
        pass_ok       = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, "alarm_ack");
        step(1);
        attempt_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_exp(1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, "alarm_hold");
            step(1);
        end
        attempt_valid = 1'b1;
        pass_ok       = 1'b1;
        push_exp(1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, "alarm_rej");
        step(1);
        attempt_valid = 1'b0;
        alarm_disable = 1'b1;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "alarm_disable");
        step(1);
        alarm_disable = 1'b0;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "after_disable");
        step(1);

        // Fire raised mid-lockout with fail_count=2.
        wrong_entry(3'd1, "f1");
        attempt_valid = 1'b1;
        pass_ok       = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, "f2_ack");
        step(1);
        attempt_valid = 1'b0;
        push_exp(1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, "f2_lock");
        step(1);
        fire_alarm = 1'b1;
        push_exp(1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "fire_enter");
        step(1);
        push_exp(1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, "fire_hold");
        step(1);
        fire_alarm = 1'b0;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "fire_exit");
        step(1);
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "fire_idle");
        step(1);

        // Fire, disable and a wrong entry in the same cycle.
        wrong_entry(3'd1, "s1");
        fire_alarm    = 1'b1;
        alarm_disable = 1'b1;
        attempt_valid = 1'b1;
        pass_ok       = 1'b0;
        push_exp(1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, "simul");
        step(1);
        fire_alarm    = 1'b0;
        alarm_disable = 1'b0;
        attempt_valid = 1'b0;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "simul_exit");
        step(1);

        // Asynchronous reset pulse between edges while the door is open.
        attempt_valid = 1'b1;
        pass_ok       = 1'b1;
        push_exp(1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, "rst_open_ack");
        step(1);
        attempt_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "async_rst");
        probe_tgl = ~probe_tgl;
        #1;
        rst_n = 1'b1;
        push_exp(1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, "post_rst_idle");
        step(1);
        wrong_entry(3'd1, "post_rst_wrong");

        step(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
